// File: rtl/nios2_oci_dct_pkg.sv
// Shared constants and types for the DCT trace packer.
package nios2_oci_dct_pkg;

    localparam int ATOM_W    = 2;
    localparam int NUM_ATOMS = 15;
    localparam int CNT_W     = 4;
    localparam int DROP_W    = 8;
    localparam int BUF_W     = ATOM_W * NUM_ATOMS;

    typedef enum logic [1:0] {
        ATOM_NOP = 2'd0,
        ATOM_NT  = 2'd1,
        ATOM_TK  = 2'd2,
        ATOM_EXC = 2'd3
    } atom_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Position an atom in its slot of an otherwise-zero buffer word.
    function automatic logic [BUF_W-1:0] place_atom(input logic [ATOM_W-1:0] code,
                                                    input logic [CNT_W-1:0]  slot);
        place_atom = BUF_W'(code) << (int'(slot) * ATOM_W);
    endfunction

endpackage

// File: rtl/nios2_oci_dct_packer_if.sv
// Packed-word output bus towards the trace FIFO (valid/ready).
interface nios2_oci_dct_packer_if;
    import nios2_oci_dct_pkg::*;

    logic             out_valid;
    logic [BUF_W-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_ready;

    modport master (output out_valid, output out_data, output out_count, input out_ready);
    modport slave  (input out_valid, input out_data, input out_count, output out_ready);
endinterface

// File: rtl/nios2_oci_dct_holdreg.sv
// One-entry output holding register; reports when it can take a new word.
module nios2_oci_dct_holdreg
    import nios2_oci_dct_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [BUF_W-1:0] load_data,
    input  logic [CNT_W-1:0] load_count,
    input  logic             out_ready,
    output logic             slot_free,
    output logic             out_valid,
    output logic [BUF_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count
);

    logic             valid_r;
    logic [BUF_W-1:0] data_r;
    logic [CNT_W-1:0] count_r;

    assign slot_free = !valid_r || out_ready;
    assign out_valid = valid_r;
    assign out_data  = data_r;
    assign out_count = count_r;

    // Refill takes priority over release so a word accepted this cycle can be replaced back-to-back.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r <= 1'b0;
            data_r  <= {BUF_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
            count_r <= load_count;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

endmodule

// File: rtl/nios2_oci_dct_packer.sv
// Packs 2-bit DCT trace atoms into 30-bit words and drives end-of-test status.
module nios2_oci_dct_packer
    import nios2_oci_dct_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      trace_enable,
    input  logic                      atom_valid,
    input  logic [ATOM_W-1:0]         atom_code,
    input  logic                      flush,
    input  logic                      end_req,
    output logic [BUF_W-1:0]          dct_buffer,
    output logic [CNT_W-1:0]          dct_count,
    nios2_oci_dct_packer_if.master    out_if,
    output logic                      overflow,
    output logic [DROP_W-1:0]         drop_count,
    output logic                      test_ending,
    output logic                      test_has_ended
);

    state_e            state_r, state_s;
    logic [BUF_W-1:0]  buf_r, buf_s, post_buf_s, load_data_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s, post_cnt_s, load_cnt_s;
    logic              pend_r, pend_s;
    logic              ovf_r, ended_r;
    logic [DROP_W-1:0] drop_r;
    logic              slot_free_s, full_s, atom_ok_s, flush_eff_s;
    logic              load_s, drop_s, end_fire_s;

    nios2_oci_dct_holdreg u_holdreg (
        .clk        (clk),
        .reset      (reset),
        .load       (load_s),
        .load_data  (load_data_s),
        .load_count (load_cnt_s),
        .out_ready  (out_if.out_ready),
        .slot_free  (slot_free_s),
        .out_valid  (out_if.out_valid),
        .out_data   (out_if.out_data),
        .out_count  (out_if.out_count)
    );

    assign dct_buffer     = buf_r;
    assign dct_count      = cnt_r;
    assign overflow       = ovf_r;
    assign drop_count     = drop_r;
    assign test_has_ended = ended_r;
    // Asserted in the same cycle as the final handshake so the monitor sees it with the word.
    assign test_ending    = end_fire_s;

    // Atom insertion, word transfer, pending-flush and drop decisions for this cycle.
    always_comb begin
        full_s      = (cnt_r == CNT_W'(NUM_ATOMS));
        atom_ok_s   = (state_r == ST_RUN) && atom_valid && (atom_code != ATOM_NOP);
        flush_eff_s = flush || pend_r || (state_r == ST_DRAIN);
        post_buf_s  = buf_r;
        post_cnt_s  = cnt_r;
        buf_s       = buf_r;
        cnt_s       = cnt_r;
        pend_s      = pend_r;
        load_s      = 1'b0;
        load_data_s = buf_r;
        load_cnt_s  = cnt_r;
        drop_s      = 1'b0;
        if (full_s) begin
            if (slot_free_s) begin
                // Ship the full word; a concurrent atom starts the next word in slot 0.
                load_s = 1'b1;
                pend_s = 1'b0;
                if (atom_ok_s) begin
                    buf_s = place_atom(atom_code, {CNT_W{1'b0}});
                    cnt_s = CNT_W'(1);
                end else begin
                    buf_s = {BUF_W{1'b0}};
                    cnt_s = {CNT_W{1'b0}};
                end
            end else begin
                drop_s = atom_ok_s;
                if (flush) begin
                    pend_s = 1'b1;
                end else begin
                    pend_s = pend_r;
                end
            end
        end else begin
            if (atom_ok_s) begin
                post_buf_s = buf_r | place_atom(atom_code, cnt_r);
                post_cnt_s = cnt_r + CNT_W'(1);
            end else begin
                post_buf_s = buf_r;
                post_cnt_s = cnt_r;
            end
            load_data_s = post_buf_s;
            load_cnt_s  = post_cnt_s;
            if (slot_free_s && ((post_cnt_s == CNT_W'(NUM_ATOMS)) ||
                                (flush_eff_s && (post_cnt_s != {CNT_W{1'b0}})))) begin
                load_s = 1'b1;
                buf_s  = {BUF_W{1'b0}};
                cnt_s  = {CNT_W{1'b0}};
                pend_s = 1'b0;
            end else begin
                buf_s = post_buf_s;
                cnt_s = post_cnt_s;
                if (flush && (post_cnt_s != {CNT_W{1'b0}})) begin
                    pend_s = 1'b1;
                end else begin
                    pend_s = pend_r;
                end
            end
        end
    end

    // Trace-session state machine: next state and end-of-test pulse.
    always_comb begin
        state_s    = state_r;
        end_fire_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (trace_enable) state_s = ST_RUN;
                else              state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (end_req)            state_s = ST_DRAIN;
                else if (!trace_enable) state_s = ST_IDLE;
                else                    state_s = ST_RUN;
            end
            ST_DRAIN: begin
                if ((cnt_r == {CNT_W{1'b0}}) && slot_free_s) begin
                    end_fire_s = 1'b1;
                    state_s    = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: state_s = ST_DONE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, packing buffer and drop/end-of-test bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            buf_r   <= {BUF_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            pend_r  <= 1'b0;
            ovf_r   <= 1'b0;
            drop_r  <= {DROP_W{1'b0}};
            ended_r <= 1'b0;
        end else begin
            state_r <= state_s;
            buf_r   <= buf_s;
            cnt_r   <= cnt_s;
            pend_r  <= pend_s;
            ovf_r   <= ovf_r | drop_s;
            if (drop_s && (drop_r != {DROP_W{1'b1}})) drop_r <= drop_r + DROP_W'(1);
            else                                      drop_r <= drop_r;
            ended_r <= ended_r | end_fire_s;
        end
    end

endmodule

// File: doc/nios2_oci_dct_packer.md
Name: nios2_oci_dct_packer

Overview:
- Upstream feeder for the OCI test-bench monitor: packs 2-bit debug compressed trace (DCT) atoms from the CPU trace tap into a 30-bit buffer.
- Exposes the live buffer and fill count (dct_buffer, dct_count) and end-of-test status (test_ending, test_has_ended) for the monitor to consume.
- Hands full or flushed words to the trace FIFO over a valid/ready handshake.

Parameters:
- ATOM_W, 2, width of one trace atom.
- NUM_ATOMS, 15, atoms per packed word; buffer width = ATOM_W*NUM_ATOMS = 30.
- CNT_W, 4, width of the atom counter; must satisfy 2^CNT_W > NUM_ATOMS.
- DROP_W, 8, width of the saturating dropped-atom counter.

Ports:
- clk  input  1  single clock; all state on its rising edge.
- reset  input  1  synchronous, active-high reset.
- trace_enable  input  1  level; atoms are accepted only while high.
- atom_valid  input  1  atom_code is valid this cycle.
- atom_code  input  2  trace atom; 2'b00 is a no-op and is ignored.
- flush  input  1  pulse; emit the partial word if count > 0.
- end_req  input  1  pulse; begin end-of-test drain.
- dct_buffer  output  30  live packing buffer.
- dct_count  output  4  atoms currently in dct_buffer (0..15).
- out_valid  output  1  output word holding register is occupied.
- out_data  output  30  packed word.
- out_count  output  4  atoms in out_data (1..15).
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready.
- overflow  output  1  sticky; at least one atom was dropped.
- drop_count  output  8  saturating count of dropped atoms.
- test_ending  output  1  one-cycle pulse when the final drain word is accepted.
- test_has_ended  output  1  sticky after test_ending.

Behaviour:
- Reset: all outputs 0; state IDLE; buffer, counters and holding register cleared. Reset mid-word discards the partial word; no emission.
- States:
  - IDLE: trace_enable=1 -> RUN.
  - RUN:
    - trace_enable=0 -> IDLE; buffer is retained.
    - end_req -> DRAIN; end_req wins over a simultaneous trace_enable drop.
  - DRAIN: atoms are ignored (not counted as dropped). Force a flush. Once the buffer is empty and the final word is accepted (or nothing was pending), pulse test_ending -> DONE.
  - DONE: terminal until reset; test_has_ended=1.
- Atom acceptance: accepted in RUN when atom_valid && atom_code != 0 && buffer not full.
  - Written to bits [2*c+1:2*c], where c = dct_count before the write; dct_count increments.
  - Visible on dct_buffer/dct_count the next cycle.
- slot_free = !out_valid || out_ready, evaluated combinationally each cycle.
- Transfer (buffer to holding register) occurs in any cycle where slot_free and one of:
  - the post-insert count is 15;
  - a flush or DRAIN flush applies with post-insert count > 0;
  - the buffer was already full (count 15).
- On transfer:
  - out_data = post-insert buffer, out_count = post-insert count, out_valid=1.
  - Buffer bits above out_count are 0.
  - Buffer clears to 0, count to 0.
- Full buffer, slot not free: buffer holds at count 15. Further valid non-no-op atoms are dropped: overflow<=1, drop_count increments, saturating at 255.
- Full buffer transferring this cycle plus an atom: the atom goes into slot 0 of the cleared buffer; count becomes 1; no drop.
- Flush with count 0 and no atom: no emission. Flush while the slot is busy: pending until slot_free; no atoms are lost while pending; a pending flush is cleared by its transfer.
- Atom + flush in the same cycle: the atom is packed first, then the word is emitted.
- Holding register: out_valid falls after acceptance unless refilled the same cycle. out_data and out_count are stable while out_valid && !out_ready.
- Latency: a completing atom appears on out_valid one cycle after its atom_valid cycle, given slot_free.

Decomposition:
- Shared package nios2_oci_dct_pkg:
  - ATOM_W, NUM_ATOMS, CNT_W constants;
  - atom code enum (NOP=0, NT=1, TK=2, EXC=3);
  - state enum (IDLE, RUN, DRAIN, DONE).
- One sub-module, nios2_oci_dct_holdreg: one-entry valid/ready output register with slot_free output.
- Packing, counter and FSM stay in the top module.

Test Plan:
- Reset, trace_enable=1, 15 atoms of code 2'b10 with out_ready=1 -> out_valid 1 cycle after the 15th atom, out_data=30'h2AAAAAAA, out_count=15, dct_count back to 0.
- 3 atoms (01, 10, 11) then flush -> out_data=30'h39, out_count=3; dct_buffer=0 afterwards.
- out_ready=0, 31 atoms -> first word held; buffer full at 15; 1 atom dropped: overflow=1, drop_count=1. Raise out_ready -> second word emitted with count 15.
- 300 excess atoms while stalled -> drop_count saturates at 255.
- 5 atoms, end_req, out_ready delayed 3 cycles -> final word count 5; test_ending pulses exactly on the acceptance cycle; test_has_ended stays 1; later atoms ignored.
- Reset asserted with count=7 and out_valid=1 -> next cycle all outputs 0; no emission.
